// File: rtl/tt_um_neuro_core.sv
// -----------------------------------------------------------------------------
// tt_um_neuro_core
//
// Single leaky integrate-and-fire neuron for the Tiny Tapeout user slot.
// Every enabled clock the 8-bit input current is added to the membrane
// potential V after a shift-based leak. The result saturates at 255. When the
// result reaches THRESH the neuron emits a one-cycle spike, V returns to 0 and
// a refractory countdown of REFRAC cycles starts. Threshold, leak shift and
// refractory length are written through a small configuration port.
//
// Optional feature macro: NEUROCORE_SPIKE_COUNT_EN
//   defined   : a 3-bit wrapping spike counter drives uio_out[6:4]
//   undefined : no counter is built and uio_out[6:4] reads 0
//
// Ports
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   ena      in   1  global enable; when low every register holds
//   ui_in    in   8  input current (unsigned), also config write data
//   uio_in   in   8  [0] cfg_we, [2:1] cfg_addr, [7:3] unused
//   uo_out   out  8  membrane potential V (registered)
//   uio_out  out  8  [7] spike, [6:4] spike count mod 8, [3:0] zero
//   uio_oe   out  8  constant 8'hF0 (upper nibble driven)
// -----------------------------------------------------------------------------
module tt_um_neuro_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // Saturate a 9-bit sum to the 8-bit membrane range.
    function automatic logic [7:0] sat8(input logic [8:0] s);
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic       unused_uio;

    assign cfg_we     = uio_in[0];
    assign cfg_addr   = uio_in[2:1];
    assign unused_uio = &{1'b0, uio_in[7:3]};

    logic [7:0] v_q,      v_d;
    logic [7:0] thresh_q, thresh_d;
    logic [2:0] leak_q,   leak_d;
    logic [3:0] refrac_q, refrac_d;
    logic [3:0] rcnt_q,   rcnt_d;
    logic       spike_q,  spike_d;
`ifdef NEUROCORE_SPIKE_COUNT_EN
    logic [2:0] scount_q, scount_d;
`endif

    // Integrate datapath. A leak shift of 0 means "no leak", not "leak all of V".
    logic [7:0] leak_amt;
    logic [7:0] v_leaked;
    logic [8:0] sum;
    logic [7:0] v_next;

    assign leak_amt = (leak_q == 3'd0) ? 8'd0 : (v_q >> leak_q);
    assign v_leaked = v_q - leak_amt;
    assign sum      = {1'b0, v_leaked} + {1'b0, ui_in};
    assign v_next   = sat8(sum);

    always_comb begin
        v_d      = v_q;
        thresh_d = thresh_q;
        leak_d   = leak_q;
        refrac_d = refrac_q;
        rcnt_d   = rcnt_q;
        spike_d  = spike_q;
`ifdef NEUROCORE_SPIKE_COUNT_EN
        scount_d = scount_q;
`endif
        if (ena) begin
            if (cfg_we) begin
                // Config cycles never integrate and always end a spike.
                spike_d = 1'b0;
                case (cfg_addr)
                    2'd0: thresh_d = ui_in;
                    2'd1: leak_d   = ui_in[2:0];
                    2'd2: refrac_d = ui_in[3:0];
                    2'd3: begin
                        v_d    = 8'd0;
                        rcnt_d = 4'd0;
`ifdef NEUROCORE_SPIKE_COUNT_EN
                        scount_d = 3'd0;
`endif
                    end
                endcase
            end else if (rcnt_q != 4'd0) begin
                rcnt_d  = rcnt_q - 4'd1;
                v_d     = 8'd0;
                spike_d = 1'b0;
            end else if (v_next >= thresh_q) begin
                spike_d = 1'b1;
                v_d     = 8'd0;
                rcnt_d  = refrac_q;
`ifdef NEUROCORE_SPIKE_COUNT_EN
                scount_d = scount_q + 3'd1;
`endif
            end else begin
                v_d     = v_next;
                spike_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q      <= 8'd0;
            thresh_q <= 8'd200;
            leak_q   <= 3'd2;
            refrac_q <= 4'd2;
            rcnt_q   <= 4'd0;
            spike_q  <= 1'b0;
`ifdef NEUROCORE_SPIKE_COUNT_EN
            scount_q <= 3'd0;
`endif
        end else begin
            v_q      <= v_d;
            thresh_q <= thresh_d;
            leak_q   <= leak_d;
            refrac_q <= refrac_d;
            rcnt_q   <= rcnt_d;
            spike_q  <= spike_d;
`ifdef NEUROCORE_SPIKE_COUNT_EN
            scount_q <= scount_d;
`endif
        end
    end

    logic [2:0] scount_out;
`ifdef NEUROCORE_SPIKE_COUNT_EN
    assign scount_out = scount_q;
`else
    assign scount_out = 3'd0;
`endif

    assign uo_out  = v_q;
    assign uio_out = {spike_q, scount_out, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_neuro_core.sv
// -----------------------------------------------------------------------------
// tb_tt_um_neuro_core
//
// Self-checking bench for tt_um_neuro_core. A behavioural LIF model written
// with plain integer arithmetic tracks the expected neuron state; directed
// scenarios exercise reset, firing, saturation, refractory length, enable
// gating, clear and asynchronous reset, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_tt_um_neuro_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    tt_um_neuro_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (plain integers).
    int m_v, m_th, m_lk, m_rf, m_rc, m_sp, m_sc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_v = 0; m_th = 200; m_lk = 2; m_rf = 2; m_rc = 0; m_sp = 0; m_sc = 0;
    endtask

    task automatic m_step(input int e, input int we, input int a, input int d);
        int lk_amt, s;
        if (e == 0) return;
        if (we != 0) begin
            m_sp = 0;
            case (a)
                0: m_th = d;
                1: m_lk = d % 8;
                2: m_rf = d % 16;
                default: begin m_v = 0; m_rc = 0; m_sc = 0; end
            endcase
        end else if (m_rc > 0) begin
            m_rc = m_rc - 1;
            m_v  = 0;
            m_sp = 0;
        end else begin
            lk_amt = (m_lk == 0) ? 0 : m_v / (1 << m_lk);
            s = m_v - lk_amt + d;
            if (s > 255) s = 255;
            if (s >= m_th) begin
                m_sp = 1; m_v = 0; m_rc = m_rf; m_sc = (m_sc + 1) % 8;
            end else begin
                m_v = s; m_sp = 0;
            end
        end
    endtask

    function automatic int exp_uio();
`ifdef NEUROCORE_SPIKE_COUNT_EN
        return m_sp * 128 + m_sc * 16;
`else
        return m_sp * 128;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".uo_out"},  uo_out,  m_v);
        chk({tag, ".uio_out"}, uio_out, exp_uio());
        chk({tag, ".uio_oe"},  uio_oe,  32'hF0);
    endtask

    // Apply one cycle of stimulus, advance the model, sample after the edge.
    task automatic cyc(input string tag, input int e, input int we, input int a, input int d);
        ena    = e[0];
        uio_in = {5'b10101, a[1:0], we[0]};
        ui_in  = d[7:0];
        m_step(e, we, a, d);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'd0;
        uio_in = 8'd0;
        m_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.uo_out",  uo_out,  0);
        chk("rst.uio_out", uio_out, 0);
        chk("rst.uio_oe",  uio_oe,  32'hF0);
        rst_n = 1'b1;

        // Default integration and fire: 100, 175, spike, 0, 0, 100
        cyc("def1", 1, 0, 0, 100);
        chk("def.v100", uo_out, 100);
        cyc("def2", 1, 0, 0, 100);
        chk("def.v175", uo_out, 175);
        cyc("def3", 1, 0, 0, 100);
        chk("def.spike", uio_out[7], 1);
        chk("def.spike_v0", uo_out, 0);
`ifdef NEUROCORE_SPIKE_COUNT_EN
        chk("def.scount1", uio_out[6:4], 1);
`endif
        cyc("def4", 1, 0, 0, 100);
        chk("def.ref1", {uio_out[7], uo_out}, 0);
        cyc("def5", 1, 0, 0, 100);
        chk("def.ref2", {uio_out[7], uo_out}, 0);
        cyc("def6", 1, 0, 0, 100);
        chk("def.resume", uo_out, 100);

        // Leak disabled and saturation
        cyc("sat.clr", 1, 1, 3, 0);
        cyc("sat.lk",  1, 1, 1, 0);
        cyc("sat.th",  1, 1, 0, 255);
        cyc("sat1", 1, 0, 0, 200);
        chk("sat.v200", uo_out, 200);
        cyc("sat2", 1, 0, 0, 200);
        chk("sat.spike", {uio_out[7], uo_out}, 9'h100);

        // Refractory length 0: spike on every integrate edge
        cyc("rf0.clr", 1, 1, 3, 0);
        cyc("rf0.rf",  1, 1, 2, 0);
        cyc("rf0.th",  1, 1, 0, 50);
        for (int i = 0; i < 5; i++) begin
            cyc("rf0", 1, 0, 0, 60);
            chk("rf0.spike", {uio_out[7], uo_out}, 9'h100);
        end

        // Refractory length 5: five zero cycles between spikes
        cyc("rf5.rf", 1, 1, 2, 5);
        cyc("rf5.s1", 1, 0, 0, 60);
        chk("rf5.spike1", uio_out[7], 1);
        for (int i = 0; i < 5; i++) begin
            cyc("rf5.gap", 1, 0, 0, 60);
            chk("rf5.quiet", {uio_out[7], uo_out}, 0);
        end
        cyc("rf5.s2", 1, 0, 0, 60);
        chk("rf5.spike2", uio_out[7], 1);

        // Enable gating and clear
        cyc("en.clr", 1, 1, 3, 0);
        cyc("en.th",  1, 1, 0, 200);
        cyc("en.lk",  1, 1, 1, 0);
        cyc("en.v",   1, 0, 0, 120);
        chk("en.v120", uo_out, 120);
        for (int i = 0; i < 8; i++) begin
            cyc("en.hold", 0, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255));
            chk("en.hold_v", uo_out, 120);
        end
        cyc("en.clear", 1, 1, 3, 0);
        chk("en.clear_v", uo_out, 0);
        chk("en.clear_sc", uio_out, 0);
        cyc("en.t1", 1, 0, 0, 120);
        cyc("en.t2", 1, 0, 0, 120);
        chk("en.thresh_kept", uio_out[7], 1);

        // Async reset mid-refractory
        cyc("ar.rf", 1, 1, 2, 5);
        cyc("ar.th", 1, 1, 0, 50);
        cyc("ar.s",  1, 0, 0, 60);
        cyc("ar.r1", 1, 0, 0, 60);
        #3;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("ar.uo_out",  uo_out,  0);
        chk("ar.uio_out", uio_out, 0);
        #1;
        rst_n = 1'b1;
        cyc("ar.i1", 1, 0, 0, 100);
        cyc("ar.i2", 1, 0, 0, 100);
        cyc("ar.i3", 1, 0, 0, 100);
        chk("ar.thresh200", uio_out[7], 1);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            int e, we, a, d;
            e  = ($urandom_range(0, 9) != 0) ? 1 : 0;
            we = ($urandom_range(0, 9) == 0) ? 1 : 0;
            a  = $urandom_range(0, 3);
            d  = $urandom_range(0, 255);
            if (we != 0 && a == 0 && $urandom_range(0, 1) == 0) d = $urandom_range(150, 255);
            cyc("rnd", e, we, a, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
